// File: rtl/bf16_pkg.sv
// Shared bf16 field widths, special encodings and the subtractor FSM state type.
package bf16_pkg;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 7;

  localparam logic [WIDTH-1:0] BF16_POS_INF = 16'h7F80;
  localparam logic [WIDTH-1:0] BF16_NEG_INF = 16'hFF80;
  localparam logic [WIDTH-1:0] BF16_QNAN    = 16'h7FC0;
  localparam logic [EXP_W-1:0] EXP_MAX      = 8'hFF;

  typedef enum logic [2:0] {IDLE, ALIGN, OPERATE, NORM, DONE} state_t;

  typedef struct packed {
    logic zero;
    logic underflow;
    logic overflow;
    logic q_nan;
    logic s_nan;
    logic positive_inf;
    logic negative_inf;
  } flags_t;

endpackage

// File: rtl/bf16_classify.sv
// Combinational bf16 operand classifier; exponent 0 counts as zero (denormals flushed).
module bf16_classify
  import bf16_pkg::*;
(
  input  logic [WIDTH-1:0] value,
  output logic             is_zero,
  output logic             is_inf,
  output logic             is_qnan,
  output logic             is_snan
);

  logic [EXP_W-1:0]  exp_f;
  logic [MANT_W-1:0] mant_f;

  assign exp_f   = value[WIDTH-2:MANT_W];
  assign mant_f  = value[MANT_W-1:0];

  assign is_zero = (exp_f == '0);
  assign is_inf  = (exp_f == EXP_MAX) && (mant_f == '0);
  assign is_qnan = (exp_f == EXP_MAX) && mant_f[MANT_W-1];
  assign is_snan = (exp_f == EXP_MAX) && (mant_f != '0) && !mant_f[MANT_W-1];

endmodule

// File: rtl/bf16_subtractor.sv
// Multi-cycle bf16 subtractor (num_1 - num_2): serial alignment, one-cycle add/sub,
// serial normalisation, truncating, with valid/ready handshakes on both sides.
module bf16_subtractor
  import bf16_pkg::*;
#(
  parameter int unsigned ALIGN_CAP = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num_1,
  input  logic [WIDTH-1:0] num_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             underflow,
  output logic             overflow,
  output logic             q_nan,
  output logic             s_nan,
  output logic             positive_inf,
  output logic             negative_inf
);

  localparam int unsigned CNT_W = (ALIGN_CAP < 1) ? 1 : $clog2(ALIGN_CAP + 1);

  state_t           state;
  flags_t           flags;
  logic             sign_a, sign_b, res_sign;
  logic [EXP_W-1:0] exp_a;
  logic [7:0]       mant_a, mant_b;
  logic [CNT_W-1:0] cnt;
  logic [EXP_W:0]   res_exp;
  logic [8:0]       res_mant;

  logic zero_1, inf_1, qnan_1, snan_1;
  logic zero_2, inf_2, qnan_2, snan_2;

  bf16_classify u_class_1 (.value(num_1), .is_zero(zero_1), .is_inf(inf_1),
                           .is_qnan(qnan_1), .is_snan(snan_1));
  bf16_classify u_class_2 (.value(num_2), .is_zero(zero_2), .is_inf(inf_2),
                           .is_qnan(qnan_2), .is_snan(snan_2));

  // Capture-time alignment decision
  logic [EXP_W-1:0] exp_1, exp_2, exp_diff;
  logic             swap, flush;
  logic [CNT_W-1:0] align_cnt;

  assign exp_1     = num_1[WIDTH-2:MANT_W];
  assign exp_2     = num_2[WIDTH-2:MANT_W];
  assign swap      = exp_2 > exp_1;
  assign exp_diff  = swap ? (exp_2 - exp_1) : (exp_1 - exp_2);
  assign flush     = 32'(exp_diff) > ALIGN_CAP;
  assign align_cnt = flush ? CNT_W'(ALIGN_CAP) : CNT_W'(exp_diff);

  logic             special, inf_sign;
  logic [WIDTH-1:0] spec_result;
  flags_t           spec_flags;

  always_comb begin
    special     = 1'b1;
    inf_sign    = 1'b0;
    spec_result = '0;
    spec_flags  = '0;
    if (snan_1 || snan_2) begin
      spec_result      = BF16_QNAN;
      spec_flags.s_nan = 1'b1;
    end else if (qnan_1 || qnan_2 || (inf_1 && inf_2 && (num_1[15] == num_2[15]))) begin
      spec_result      = BF16_QNAN;
      spec_flags.q_nan = 1'b1;
    end else if (inf_1 || inf_2) begin
      // num_2 enters with its sign inverted
      inf_sign                = inf_1 ? num_1[15] : ~num_2[15];
      spec_result             = inf_sign ? BF16_NEG_INF : BF16_POS_INF;
      spec_flags.positive_inf = ~inf_sign;
      spec_flags.negative_inf = inf_sign;
    end else if (zero_1 && zero_2) begin
      spec_flags.zero = 1'b1;
    end else if (zero_1) begin
      spec_result = {~num_2[15], num_2[14:0]};
    end else if (zero_2) begin
      spec_result = num_1;
    end else begin
      special = 1'b0;
    end
  end

  logic       eff_add, a_ge_b, op_sign;
  logic [8:0] op_mant;

  assign eff_add = (sign_a == sign_b);
  assign a_ge_b  = (mant_a >= mant_b);
  assign op_sign = (eff_add || a_ge_b) ? sign_a : sign_b;
  assign op_mant = eff_add ? ({1'b0, mant_a} + {1'b0, mant_b}) :
                   a_ge_b  ? {1'b0, mant_a - mant_b} : {1'b0, mant_b - mant_a};

  logic [8:0]     nrm_mant;
  logic [EXP_W:0] nrm_exp;

  assign nrm_mant = res_mant[8] ? (res_mant >> 1) : (res_mant << 1);
  assign nrm_exp  = res_mant[8] ? (res_exp + 9'd1) : (res_exp - 9'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      result   <= '0;
      flags    <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      exp_a    <= '0;
      mant_a   <= '0;
      mant_b   <= '0;
      cnt      <= '0;
      res_sign <= 1'b0;
      res_exp  <= '0;
      res_mant <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          if (special) begin
            result <= spec_result;
            flags  <= spec_flags;
            state  <= DONE;
          end else begin
            flags <= '0;
            if (swap) begin
              sign_a <= ~num_2[15];
              exp_a  <= exp_2;
              mant_a <= {1'b1, num_2[6:0]};
              sign_b <= num_1[15];
              mant_b <= flush ? 8'h00 : {1'b1, num_1[6:0]};
            end else begin
              sign_a <= num_1[15];
              exp_a  <= exp_1;
              mant_a <= {1'b1, num_1[6:0]};
              sign_b <= ~num_2[15];
              mant_b <= flush ? 8'h00 : {1'b1, num_2[6:0]};
            end
            cnt   <= align_cnt;
            state <= (align_cnt != '0) ? ALIGN : OPERATE;
          end
        end
        ALIGN: begin
          mant_b <= mant_b >> 1;
          cnt    <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= OPERATE;
        end
        OPERATE: begin
          if (op_mant == '0) begin
            result     <= '0;
            flags.zero <= 1'b1;
            state      <= DONE;
          end else if (op_mant[8:7] == 2'b01) begin
            result <= {op_sign, exp_a, op_mant[6:0]};
            state  <= DONE;
          end else begin
            res_sign <= op_sign;
            res_exp  <= {1'b0, exp_a};
            res_mant <= op_mant;
            state    <= NORM;
          end
        end
        NORM: begin
          if (nrm_exp >= {1'b0, EXP_MAX}) begin
            result             <= {res_sign, EXP_MAX, 7'h00};
            flags.overflow     <= 1'b1;
            flags.positive_inf <= ~res_sign;
            flags.negative_inf <= res_sign;
            state              <= DONE;
          end else if (nrm_exp == '0) begin
            result          <= {res_sign, 15'h0000};
            flags.underflow <= 1'b1;
            state           <= DONE;
          end else if (nrm_mant[7]) begin
            result <= {res_sign, nrm_exp[7:0], nrm_mant[6:0]};
            state  <= DONE;
          end else begin
            res_exp  <= nrm_exp;
            res_mant <= nrm_mant;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign {zero, underflow, overflow, q_nan, s_nan, positive_inf, negative_inf} = flags;

endmodule

// File: tb/tb_bf16_subtractor.sv
// Scoreboard bench for bf16_subtractor: driver queues hand-computed results, monitor checks.
module tb_bf16_subtractor;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] num_1, num_2, result;
  logic        zero, underflow, overflow, q_nan, s_nan, positive_inf, negative_inf;
  logic [6:0]  flg_act;

  localparam logic [6:0] F_NONE = 7'b0000000;
  localparam logic [6:0] F_ZERO = 7'b1000000;
  localparam logic [6:0] F_UNF  = 7'b0100000;
  localparam logic [6:0] F_OVF  = 7'b0010000;
  localparam logic [6:0] F_QNAN = 7'b0001000;
  localparam logic [6:0] F_SNAN = 7'b0000100;
  localparam logic [6:0] F_PINF = 7'b0000010;
  localparam logic [6:0] F_NINF = 7'b0000001;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic [6:0]  flg;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cycle = 0;

  bf16_subtractor #(.ALIGN_CAP(9)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .num_1(num_1), .num_2(num_2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .underflow(underflow), .overflow(overflow),
    .q_nan(q_nan), .s_nan(s_nan), .positive_inf(positive_inf), .negative_inf(negative_inf)
  );

  assign flg_act = {zero, underflow, overflow, q_nan, s_nan, positive_inf, negative_inf};

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: compares every DONE cycle (stability), latency on the first one.
  initial begin : monitor
    exp_t e;
    bit   seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!out_valid) begin
        seen = 1'b0;
      end else if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: result=%h flags=%b, required no output",
                 result, flg_act);
      end else begin
        e = sb[0];
        n_cmp++;
        if (result !== e.res || flg_act !== e.flg) begin
          n_bad++;
          $display("FAIL %s: result=%h flags=%b, required result=%h flags=%b",
                   e.name, result, flg_act, e.res, e.flg);
        end
        if (!seen) begin
          n_cmp++;
          if (cycle != e.due) begin
            n_bad++;
            $display("FAIL %s_latency: valid at cycle %0d, required cycle %0d",
                     e.name, cycle, e.due);
          end
        end
        seen = 1'b1;
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // lat = edges after the accepting edge until out_valid; hold = extra DONE cycles
  task automatic run(input string name, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] res, input logic [6:0] flg, input int lat,
                     input int hold);
    exp_t e;
    int   k;
    @(posedge clk); #1;
    num_1     = a;
    num_2     = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    e.name = name;
    e.res  = res;
    e.flg  = flg;
    e.due  = cycle + 1 + lat;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    num_1    = ~a;
    num_2    = 16'($urandom());
    if (hold > 0) begin
      k = 0;
      while (!out_valid && k < 40) begin
        @(posedge clk); #1;
        k++;
      end
      repeat (hold) @(posedge clk);
      #1 out_ready = 1'b1;
    end
    k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: no result after %0d cycles, required one", name, k);
      sb.delete();
    end
    out_ready = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    num_1     = '0;
    num_2     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", 32'(result), 32'h0);
    check("reset_flags", 32'(flg_act), 32'h0);
    rst = 1'b0;

    run("sub_3_1",       16'h4040, 16'h3F80, 16'h4000, F_NONE,         2, 0);
    run("sub_equal",     16'h3F80, 16'h3F80, 16'h0000, F_ZERO,         1, 0);
    run("sub_neg_right", 16'h3F80, 16'hBF80, 16'h4000, F_NONE,         2, 0);
    run("ovf_pos",       16'h7F00, 16'hFF00, 16'h7F80, F_OVF | F_PINF, 2, 0);
    run("ovf_neg",       16'hFF00, 16'h7F00, 16'hFF80, F_OVF | F_NINF, 2, 0);
    run("inf_inf",       16'h7F80, 16'h7F80, 16'h7FC0, F_QNAN,         0, 0);
    run("snan",          16'h7F81, 16'h3F80, 16'h7FC0, F_SNAN,         0, 0);
    run("qnan",          16'h7FC1, 16'h3F80, 16'h7FC0, F_QNAN,         0, 0);
    run("ninf_op1",      16'hFF80, 16'h3F80, 16'hFF80, F_NINF,         0, 0);
    run("ninf_op2",      16'h3F80, 16'hFF80, 16'h7F80, F_PINF,         0, 0);
    run("zero_op1",      16'h0000, 16'h4040, 16'hC040, F_NONE,         0, 0);
    run("zero_op2",      16'h4040, 16'h8000, 16'h4040, F_NONE,         0, 0);
    run("zero_both",     16'h8000, 16'h0000, 16'h0000, F_ZERO,         0, 0);
    run("swap_neg",      16'h3F80, 16'h4000, 16'hBF80, F_NONE,         3, 0);
    run("half_pos",      16'h3FC0, 16'h3F80, 16'h3F00, F_NONE,         2, 0);
    run("half_neg",      16'h3F80, 16'h3FC0, 16'hBF00, F_NONE,         2, 0);
    run("truncate",      16'h3FFF, 16'hBF80, 16'h403F, F_NONE,         2, 0);
    run("align_cap",     16'h4B00, 16'h3F80, 16'h4B00, F_NONE,        10, 0);
    run("underflow",     16'h00C0, 16'h0080, 16'h0000, F_UNF,          2, 0);
    run("hold_stable",   16'h4040, 16'h3F80, 16'h4000, F_NONE,         2, 3);

    // Reset mid-ALIGN with the consumer stalled; no result may appear afterwards
    @(posedge clk); #1;
    num_1     = 16'h4100;
    num_2     = 16'h3F80;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("align_busy_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", 32'(result), 32'h0);
    check("midrst_flags", 32'(flg_act), 32'h0);
    repeat (8) @(posedge clk);
    #1;
    check("midrst_no_stale", 32'(out_valid), 32'd0);

    run("after_reset",   16'h4100, 16'h3F80, 16'h40E0, F_NONE,         5, 0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bf16_subtractor.md
BF16_SUBTRACTOR -- requirements
Module: bf16_subtractor

Interface
REQ-001 SHALL have parameter ALIGN_CAP, default 9: maximum alignment shift count; larger exponent differences flush the smaller mantissa to 0.
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand pair valid.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port num_1  input  16  bf16 minuend.
REQ-007 SHALL have port num_2  input  16  bf16 subtrahend.
REQ-008 SHALL have port out_valid  output  1  result and flags valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port result  output  16  bf16 value of num_1 - num_2.
REQ-011 SHALL have ports zero, underflow, overflow, q_nan, s_nan, positive_inf, negative_inf  output  1 each  status flags qualified by out_valid.

Function
REQ-012 SHALL use states IDLE, ALIGN, OPERATE, NORM and DONE; in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-013 SHALL register num_1 and num_2 on the in_valid&&in_ready edge, then ignore the inputs until the next return to IDLE.
REQ-014 SHALL treat exponent 0 as signed zero (denormals flushed) and perform no rounding (truncate).
REQ-015 SHALL classify operands at capture and go straight to DONE for specials: sNaN (exp FF, mant!=0, mant[6]=0) -> 7FC0 with s_nan; qNaN -> 7FC0 with q_nan; inf-inf with same sign -> 7FC0 with q_nan; otherwise an inf operand -> the correctly signed inf (7F80/FF80) with positive_inf or negative_inf; zero operand -> the other operand, with num_2 sign inverted; both zero -> 0000 with zero.
REQ-016 SHALL otherwise negate sign_2, select the larger-exponent operand as the base, load the count A=min(|exp_1-exp_2|, ALIGN_CAP), and enter ALIGN if A>0 or OPERATE if A=0.
REQ-017 In ALIGN, SHALL shift the smaller {1,mant} right by 1 bit per cycle and decrement A; at 0 it SHALL go to OPERATE.
REQ-018 In OPERATE, SHALL compute in one cycle a 9-bit sum (equal effective signs) or magnitude difference (unequal signs; the result takes the larger magnitude's sign; ties by mantissa at equal exponent).
REQ-019 On a zero difference, OPERATE SHALL go to DONE with result 0000 and zero=1.
REQ-020 In NORM, SHALL shift right once with exp+1 if mant[8]=1, else shift left with exp-1 once per cycle until mant[7]=1; N denotes the NORM cycle count.
REQ-021 SHALL force exponent >=255 to result {sign,FF,00} with overflow and the matching inf flag set.
REQ-022 SHALL stop NORM if the exponent reaches 0 and output {sign,15'b0} with underflow=1.
REQ-023 SHALL raise out_valid A+N+1 edges after the accepting edge; specials SHALL take 1 edge.
REQ-024 SHALL hold result and flags stable in DONE until out_ready=1, then go to IDLE; there SHALL be no back-to-back accept in the same cycle.

Reset
REQ-025 On rst=1 at a clock edge, SHALL enter IDLE and set out_valid=0, in_ready=1, result=0000 and all flags to 0 from any state, including mid-ALIGN or NORM.
REQ-026 SHALL discard an in-flight operation on reset and produce no result for it.

Structure
REQ-027 SHALL take the following from shared package bf16_pkg: the field widths, constants BF16_POS_INF=7F80, BF16_NEG_INF=FF80, BF16_QNAN=7FC0 and EXP_MAX=FF, and the FSM state typedef.
REQ-028 SHALL instantiate one combinational sub-module, bf16_classify, per operand, flagging zero, inf, qnan and snan.

Verification
REQ-029 SHALL cover 4040-3F80 -> result 4000, out_valid 2 edges after accept, all flags 0.
REQ-030 SHALL cover 3F80-3F80 -> result 0000, zero=1, latency 1.
REQ-031 SHALL cover 3F80-BF80 -> result 4000 via NORM right shift, latency 2.
REQ-032 SHALL cover 7F00-FF00 -> result 7F80, overflow=1, positive_inf=1.
REQ-033 SHALL cover 7F80-7F80 -> result 7FC0, q_nan=1; and 7F81-3F80 -> result 7FC0, s_nan=1.
REQ-034 SHALL cover rst asserted during ALIGN of 4100-3F80 with out_ready held 0 -> next cycle in_ready=1, out_valid=0, and no stale result afterwards.
